// File: rtl/rs_wide_add_seq.sv
// Wide add/subtract computed one CHUNK_WIDTH slice per clock on a single carry chain.
// Y = A + (BI ? ~B : B) + CI, with carry-out and signed overflow of the full word.
module rs_wide_add_seq #(
   parameter int DATA_WIDTH  = 64,
   parameter int CHUNK_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic                  bi,
   input  logic                  ci,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] sum,
   output logic                  co,
   output logic                  ovf,
   output logic                  busy
);

   localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
   localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NUM_CHUNKS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   a_q, a_d;
   logic [DATA_WIDTH-1:0]   b_q, b_d;
   logic                    carry_q, carry_d;
   logic [CNT_W-1:0]        k_q, k_d;
   logic [DATA_WIDTH-1:0]   sum_q, sum_d;
   logic                    co_q, co_d;
   logic                    ovf_q, ovf_d;
   logic                    out_valid_q, out_valid_d;

   logic [CHUNK_WIDTH-1:0]  a_chunk;
   logic [CHUNK_WIDTH-1:0]  b_chunk;
   logic [CHUNK_WIDTH:0]    add_res;

   // The one shared carry chain: current slice of A and B' plus the running carry.
   always_comb begin
      a_chunk = a_q[k_q*CHUNK_WIDTH +: CHUNK_WIDTH];
      b_chunk = b_q[k_q*CHUNK_WIDTH +: CHUNK_WIDTH];
      add_res = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK_WIDTH{1'b0}}, carry_q};
   end

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
   // in_ready is 1 only in IDLE, out_valid holds sum/co/ovf stable until out_ready.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      carry_d     = carry_q;
      k_d         = k_q;
      sum_d       = sum_q;
      co_d        = co_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = bi ? ~b : b;
               carry_d = ci;
               k_d     = '0;
               sum_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[k_q*CHUNK_WIDTH +: CHUNK_WIDTH] = add_res[CHUNK_WIDTH-1:0];
            carry_d = add_res[CHUNK_WIDTH];
            if (k_q == LAST_K) begin
               co_d        = add_res[CHUNK_WIDTH];
               // MSB of the last slice is the sign bit of the whole word.
               ovf_d       = (a_chunk[CHUNK_WIDTH-1] == b_chunk[CHUNK_WIDTH-1]) &&
                             (add_res[CHUNK_WIDTH-1] != a_chunk[CHUNK_WIDTH-1]);
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         carry_q     <= 1'b0;
         k_q         <= '0;
         sum_q       <= '0;
         co_q        <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         carry_q     <= carry_d;
         k_q         <= k_d;
         sum_q       <= sum_d;
         co_q        <= co_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign co        = co_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_rs_wide_add_seq.sv
// Bench for rs_wide_add_seq: directed corner cases plus random operands, checked by a
// scoreboard fed from an integer-arithmetic model of Y = A + (BI ? ~B : B) + CI.
module tb_rs_wide_add_seq;

   localparam int DW = 64;
   localparam int CW = 16;
   localparam int NC = DW / CW;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] a;
   logic [DW-1:0] b;
   logic          bi;
   logic          ci;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] sum;
   logic          co;
   logic          ovf;
   logic          busy;

   int checks = 0;
   int errors = 0;
   logic [DW+1:0] exp_q[$];   // {sum, co, ovf}

   rs_wide_add_seq #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bi(bi), .ci(ci),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .co(co), .ovf(ovf), .busy(busy)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s timed out", name);
   endtask

   // Unsigned sum gives sum/co; overflow is the exact signed result leaving 64-bit range.
   function automatic logic [DW+1:0] model(input logic [DW-1:0] ma, input logic [DW-1:0] mb,
                                          input logic mbi, input logic mci);
      logic [DW-1:0]        bb;
      logic [DW+1:0]        u;
      logic signed [DW+1:0] t;
      logic signed [DW+1:0] smax;
      logic signed [DW+1:0] smin;
      logic                 ov;
      bb   = mbi ? ~mb : mb;
      u    = {2'b00, ma} + {2'b00, bb} + {{(DW+1){1'b0}}, mci};
      t    = $signed({{2{ma[DW-1]}}, ma}) + $signed({{2{bb[DW-1]}}, bb}) +
             $signed({{(DW+1){1'b0}}, mci});
      smax = $signed({3'b000, {(DW-1){1'b1}}});
      smin = $signed({3'b111, {(DW-1){1'b0}}});
      ov   = (t > smax) || (t < smin);
      return {u[DW-1:0], u[DW], ov};
   endfunction

   function automatic logic [DW-1:0] rnd_op();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return {1'b1, {(DW-1){1'b0}}};
         3:       return {1'b0, {(DW-1){1'b1}}};
         default: return {$urandom, $urandom};
      endcase
   endfunction

   // ---------------- driver tasks ----------------
   task automatic do_op(input logic [DW-1:0] ta, input logic [DW-1:0] tb, input logic tbi,
                        input logic tci);
      int n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         timeout_fail("accept_wait");
         return;
      end
      a = ta; b = tb; bi = tbi; ci = tci;
      in_valid = 1'b1;
      @(posedge clk);
      exp_q.push_back(model(ta, tb, tbi, tci));
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_q.size() != 0) timeout_fail("drain");
   endtask

   task automatic drain_random_ready();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk); #1;
         out_ready = 1'($urandom_range(0, 1));
         n++;
      end
      out_ready = 1'b1;
      if (exp_q.size() != 0) timeout_fail("drain_random");
   endtask

   task automatic check_latency(input string name);
      int cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1) begin
            check({name, "_in_ready_run"}, in_ready, 0);
            check({name, "_busy_run"}, busy, 1);
         end
      end
      check({name, "_latency"}, cyc, NC);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin : monitor
      logic [DW+1:0] e;
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output sum=%h co=%b ovf=%b", sum, co, ovf);
         end else begin
            e = exp_q.pop_front();
            check("sum", sum, e[DW+1:2]);
            check("co", co, e[1]);
            check("ovf", ovf, e[0]);
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin : main
      logic [DW+1:0] e;
      logic [DW-1:0] na;
      logic [DW-1:0] nb;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bi = 1'b0; ci = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_sum", sum, 0);
      check("rst_co", co, 0);
      check("rst_ovf", ovf, 0);

      // carry across a chunk boundary, with latency
      do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
      check_latency("boundary");
      drain();
      // full-width ripple, signed overflow, subtract with and without borrow
      do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
      drain();
      do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
      drain();
      do_op(64'd5, 64'd7, 1'b1, 1'b1);
      drain();
      do_op(64'd7, 64'd5, 1'b1, 1'b1);
      drain();

      // backpressure while a new request is presented
      out_ready = 1'b0;
      do_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b1);
      e = model(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b1);
      begin
         int n = 0;
         while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
         end
         if (!out_valid) timeout_fail("bp_out_valid");
      end
      na = {$urandom, $urandom};
      nb = {$urandom, $urandom};
      a = na; b = nb; bi = 1'b0; ci = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp_out_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
         check("bp_sum", sum, e[DW+1:2]);
         check("bp_co", co, e[1]);
         check("bp_ovf", ovf, e[0]);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_idle_in_ready", in_ready, 1);
      check("bp_idle_busy", busy, 0);
      check("bp_idle_out_valid", out_valid, 0);
      @(posedge clk);
      exp_q.push_back(model(na, nb, 1'b0, 1'b1));
      #1 in_valid = 1'b0;
      check("bp_new_busy", busy, 1);
      drain();

      // reset in RUN with k=2
      do_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_sum", sum, 0);
      check("mid_rst_co", co, 0);
      do_op(64'h1234, 64'h1, 1'b0, 1'b0);
      check_latency("after_rst");
      drain();

      // random operands with random consumer stalls
      for (int i = 0; i < 30; i++) begin
         do_op(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         drain_random_ready();
      end

      out_ready = 1'b1;
      drain();
      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/rs_wide_add_seq.md
# rs_wide_add_seq

Multi-cycle sequencer that computes a wide add/subtract by time-multiplexing one CHUNK_WIDTH-bit carry-chain adder over DATA_WIDTH-bit operands, one chunk per clock, carrying the inter-chunk carry in a register. It sits between a valid/ready producer and consumer wherever an operand is wider than one carry chain can map. Combining chunks sequentially avoids cascading multiple chains. Semantics match the `$alu` cell: Y = A + (BI ? ~B : B) + CI.

## Interface
- DATA_WIDTH, 64, operand/result width; must be an integer multiple of CHUNK_WIDTH
- CHUNK_WIDTH, 16, bits added per cycle; 3 ≤ CHUNK_WIDTH ≤ device max carry-chain length
- NUM_CHUNKS, DATA_WIDTH/CHUNK_WIDTH (derived, localparam); must be ≥ 1
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- a  in  DATA_WIDTH  operand A
- b  in  DATA_WIDTH  operand B
- bi  in  1  invert B (subtract)
- ci  in  1  carry-in to chunk 0
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  DATA_WIDTH  result Y
- co  out  1  carry-out of bit DATA_WIDTH-1
- ovf  out  1  signed overflow
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE. Reset values: in_ready=1, out_valid=0, busy=0, sum=0, co=0, ovf=0, chunk counter=0, carry register=0.
- In IDLE, in_ready=1. When in_valid&&in_ready, the following are captured:
  - a into the A register.
  - bi ? ~b : b into the B register.
  - ci into the carry register.
  - The chunk counter k is cleared to 0.
  - sum is cleared.
  - The state moves to RUN.
- In RUN, each cycle computes {c, s} = A[k] + B[k] + carry, where [k] is bits k·CHUNK_WIDTH +: CHUNK_WIDTH.
  - s is registered into sum[k] and c into carry.
  - k is incremented.
- On the cycle where k = NUM_CHUNKS-1, the state moves to DONE instead of incrementing:
  - co is set to c.
  - ovf is set to (A[MSB] == B'[MSB]) && (s[MSB] != A[MSB]), where B' is the stored, possibly inverted operand.
- In DONE, out_valid=1 and sum/co/ovf are held stable. On out_valid&&out_ready the state returns to IDLE.
- Only the currently registered operands are used. Changes on a/b/bi/ci outside the accept cycle are ignored.
- in_ready=0 in RUN and DONE. in_valid is ignored there; no queuing and no error flag.
- Counter width is clog2(NUM_CHUNKS), minimum 1. The counter never wraps past NUM_CHUNKS-1.
- NUM_CHUNKS=1 is legal: RUN lasts one cycle.
- rst asserted in any state returns all state and outputs to reset values at the next edge. It overrides a same-cycle handshake.

## Timing
- Accept edge E0 → chunk i registered at edge E(i+1) → out_valid=1 after edge E_NUM_CHUNKS. Latency is NUM_CHUNKS cycles from acceptance to out_valid.
- With out_ready held at 1, the handshake occurs on edge E(NUM_CHUNKS+1) and IDLE is reached. The next accept is at E(NUM_CHUNKS+2). Maximum throughput is one operation per NUM_CHUNKS+2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs, except:
  - in_ready and busy are decoded from state only.
- sum chunks become visible progressively during RUN. sum is only valid while out_valid=1.
- Critical path: one CHUNK_WIDTH adder plus carry mux. It must map onto a single carry chain.

## Test plan
- Config for all tests: DATA_WIDTH=64, CHUNK_WIDTH=16.
- **Carry across a chunk boundary:** a=0x0000_0000_0000_FFFF, b=1, bi=0, ci=0 → sum=0x0000_0000_0001_0000, co=0, ovf=0; out_valid rises exactly 4 cycles after acceptance.
- **Full-width carry ripple:** a=0xFFFF_FFFF_FFFF_FFFF, b=1, bi=0, ci=0 → sum=0, co=1, ovf=0.
- **Signed overflow:** a=0x7FFF_FFFF_FFFF_FFFF, b=1, bi=0, ci=0 → sum=0x8000_0000_0000_0000, co=0, ovf=1.
- **Subtract with borrow:** a=5, b=7, bi=1, ci=1 → sum=0xFFFF_FFFF_FFFF_FFFE, co=0, ovf=0. Also a=7, b=5, bi=1, ci=1 → sum=2, co=1.
- **Backpressure:** hold out_ready=0 for 10 cycles after out_valid while driving in_valid=1 with new operands. Required: sum/co/ovf/out_valid stable, in_ready=0, new request not taken. After out_ready=1 for one edge: IDLE, in_ready=1, the new request is accepted on the following edge and computed correctly.
- **Reset mid-operation:** assert rst for one cycle during RUN with k=2. Next cycle: out_valid=0, in_ready=1, busy=0, sum=0. A subsequent 0x1234 + 0x1 returns 0x1235 with normal latency.
